my_counter_n: RTL and testbench

- Parametrised, registered up/down counter with load and clear. Successor to the 16-bit combinational incrementer.
- Adds a programmable step, direction control, and a wrap-or-saturate mode.
- Provides sticky overflow and terminal-count status.
- Serves as the program-counter / loop-counter register in the CPU datapath and as a general event counter.

---
 rtl/my_counter_n.sv | 87 ++++++++
 tb/tb_my_counter_n.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_counter_n.sv
// Registered up/down counter with programmable step, load, clear and
// wrap-or-saturate overflow handling; sticky ovf plus one-cycle tc pulse.
module my_counter_n #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             tc,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             tc_reg;
    logic             tc_next;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             borrow;
    logic             wrap_hit;
    logic [WIDTH-1:0] step_result;
    logic [WIDTH-1:0] final_result;

    // One extra bit on the adder so the carry out is exact for any step.
    assign sum_ext     = {1'b0, count_reg} + {1'b0, step};
    assign diff        = count_reg - step;
    assign carry       = sum_ext[WIDTH];
    assign borrow      = (step > count_reg);
    assign wrap_hit    = dir ? carry : borrow;
    assign step_result = dir ? sum_ext[WIDTH-1:0] : diff;

    generate
        if (SATURATE) begin : g_saturate
            assign final_result = !wrap_hit ? step_result : (dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
        end else begin : g_wrap
            assign final_result = step_result;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        ovf_next   = ovf_reg;
        tc_next    = 1'b0;
        if (clr) begin
            count_next = RESET_VALUE;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = load_val;
            ovf_next   = 1'b0;
        end else if (en) begin
            count_next = final_result;
            tc_next    = wrap_hit;
            ovf_next   = ovf_reg | wrap_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= RESET_VALUE;
            ovf_reg   <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            tc_reg    <= tc_next;
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;
    assign tc    = tc_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: tb/tb_my_counter_n.sv
// Self-checking bench for my_counter_n: directed vector table on 16-bit
// wrap/saturate instances, then a randomized 4-bit sweep against a model.
module tb_my_counter_n;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic        en;
    logic        dir;
    logic [15:0] load_val;
    logic [15:0] step;

    logic [15:0] count_w16, count_s16;
    logic [3:0]  count_w4, count_s4;
    logic        ovf_w16, ovf_s16, ovf_w4, ovf_s4;
    logic        tc_w16, tc_s16, tc_w4, tc_s4;
    logic        zero_w16, zero_s16, zero_w4, zero_s4;

    int checks = 0;
    int errors = 0;

    my_counter_n #(.WIDTH(16), .RESET_VALUE(16'h0010), .SATURATE(1'b0)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .count(count_w16), .ovf(ovf_w16), .tc(tc_w16), .zero(zero_w16));

    my_counter_n #(.WIDTH(16), .RESET_VALUE(16'h0010), .SATURATE(1'b1)) dut_s16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step),
        .count(count_s16), .ovf(ovf_s16), .tc(tc_s16), .zero(zero_s16));

    my_counter_n #(.WIDTH(4), .RESET_VALUE(4'h3), .SATURATE(1'b0)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .dir(dir), .step(step[3:0]),
        .count(count_w4), .ovf(ovf_w4), .tc(tc_w4), .zero(zero_w4));

    my_counter_n #(.WIDTH(4), .RESET_VALUE(4'h3), .SATURATE(1'b1)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .dir(dir), .step(step[3:0]),
        .count(count_s4), .ovf(ovf_s4), .tc(tc_s4), .zero(zero_s4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          sel;
        logic        clr;
        logic        load;
        logic        en;
        logic        dir;
        logic [15:0] load_val;
        logic [15:0] step;
        logic [15:0] exp_count;
        logic        exp_ovf;
        logic        exp_tc;
    } vec_t;

    typedef struct {
        int          sel;
        int          id;
        logic [15:0] count;
        logic        ovf;
        logic        tc;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [15:0] count;
        logic        ovf;
        logic        tc;
    } mstate_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(int sel, logic c, logic l, logic e, logic d,
                                logic [15:0] lv, logic [15:0] st,
                                logic [15:0] ec, logic eo, logic et);
        vec_t v;
        v.sel = sel; v.clr = c; v.load = l; v.en = e; v.dir = d;
        v.load_val = lv; v.step = st;
        v.exp_count = ec; v.exp_ovf = eo; v.exp_tc = et;
        return v;
    endfunction

    function automatic string tag(int sel);
        case (sel)
            0: return "w16";
            1: return "s16";
            2: return "w4";
            default: return "s4";
        endcase
    endfunction

    function automatic logic [18:0] actual(int sel);
        case (sel)
            0: return {count_w16, ovf_w16, tc_w16, zero_w16};
            1: return {count_s16, ovf_s16, tc_s16, zero_s16};
            2: return {12'h000, count_w4, ovf_w4, tc_w4, zero_w4};
            default: return {12'h000, count_s4, ovf_s4, tc_s4, zero_s4};
        endcase
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compare(exp_t e);
        logic [18:0] a;
        string       n;
        a = actual(e.sel);
        n = $sformatf("%s[%0d]", tag(e.sel), e.id);
        check({n, " count"}, a[18:3], e.count);
        check({n, " ovf"}, {15'd0, a[2]}, {15'd0, e.ovf});
        check({n, " tc"}, {15'd0, a[1]}, {15'd0, e.tc});
        check({n, " zero"}, {15'd0, a[0]}, {15'd0, e.zero});
        $display("txn %s count=%0h ovf=%0b tc=%0b zero=%0b", n, a[18:3], a[2], a[1], a[0]);
    endtask

    task automatic drive(logic c, logic l, logic e, logic d, logic [15:0] lv, logic [15:0] st);
        clr = c; load = l; en = e; dir = d; load_val = lv; step = st;
    endtask

    task automatic push(int sel, int id, logic [15:0] c, logic o, logic t);
        exp_t e;
        e.sel = sel; e.id = id; e.count = c; e.ovf = o; e.tc = t; e.zero = (c == 16'h0000);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(e);
        end
    endtask

    // Independent reference: carry detected by comparing the full sum to the max value.
    function automatic mstate_t model(mstate_t s, int w, bit sat, logic [15:0] rv,
                                      logic c, logic l, logic e, logic d,
                                      logic [15:0] lv, logic [15:0] st);
        mstate_t     n;
        int unsigned mask, cur, stp, sum;
        mask = (32'd1 << w) - 1;
        cur  = 32'(s.count) & mask;
        stp  = 32'(st) & mask;
        n    = s;
        n.tc = 1'b0;
        if (c) begin
            n.count = rv & 16'(mask); n.ovf = 1'b0;
        end else if (l) begin
            n.count = lv & 16'(mask); n.ovf = 1'b0;
        end else if (e) begin
            if (d) begin
                sum = cur + stp;
                if (sum > mask) begin
                    n.tc = 1'b1; n.ovf = 1'b1;
                    n.count = sat ? 16'(mask) : 16'(sum & mask);
                end else begin
                    n.count = 16'(sum);
                end
            end else begin
                if (stp > cur) begin
                    n.tc = 1'b1; n.ovf = 1'b1;
                    n.count = sat ? 16'h0000 : 16'((cur - stp) & mask);
                end else begin
                    n.count = 16'(cur - stp);
                end
            end
        end
        return n;
    endfunction

    mstate_t mw4, ms4;

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        #1 rst_n = 1'b0;
        #2;
        // Asynchronous reset values, visible before any clock edge.
        for (int s = 0; s < 4; s++)
            push(s, 0, (s < 2) ? 16'h0010 : 16'h0003, 1'b0, 1'b0);
        while (exp_q.size() > 0) compare(exp_q.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 16'h0001, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0005, 16'h0000, 16'h0005, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 16'h0003, 16'h0002, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 16'h0003, 16'h0000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 16'h0003, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 16'h1234, 16'h0005, 16'h0010, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h1234, 16'h0005, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0100, 16'h00FF, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h00FF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h00FF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0007, 16'h00FF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0009, 16'h00FF, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'hFFFF, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].dir, tbl[i].load_val, tbl[i].step);
            push(tbl[i].sel, i, tbl[i].exp_count, tbl[i].exp_ovf, tbl[i].exp_tc);
            tick();
        end

        // Reset asserted mid-count while a tc pulse is pending.
        drive(0, 1, 0, 0, 16'hFFFF, 16'h0000);
        push(0, 100, 16'hFFFF, 0, 0);
        tick();
        drive(0, 0, 1, 1, 16'h0000, 16'h0001);
        push(0, 101, 16'h0000, 1, 1);
        tick();
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        push(0, 102, 16'h0010, 0, 0);
        while (exp_q.size() > 0) compare(exp_q.pop_front());
        push(0, 103, 16'h0010, 0, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized 4-bit sweep, both wrap and saturate instances.
        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        mw4 = '{count: 16'h0003, ovf: 1'b0, tc: 1'b0};
        ms4 = mw4;
        push(2, 0, mw4.count, mw4.ovf, mw4.tc);
        push(3, 0, ms4.count, ms4.ovf, ms4.tc);
        tick();
        for (int i = 1; i <= 1000; i++) begin
            logic        c, l, e, d;
            logic [15:0] lv, st;
            c  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            lv = 16'($urandom);
            st = 16'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            drive(c, l, e, d, lv, st);
            mw4 = model(mw4, 4, 1'b0, 16'h0003, c, l, e, d, lv, st);
            ms4 = model(ms4, 4, 1'b1, 16'h0003, c, l, e, d, lv, st);
            push(2, i, mw4.count, mw4.ovf, mw4.tc);
            push(3, i, ms4.count, ms4.ovf, ms4.tc);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
